// File: rtl/somador_datapath.sv
// somador_datapath
//   Datapath for the summation control FSM. Holds the 32-word operand/result
//   memory, the operand register and the accumulator, and writes each 8-word
//   group sum back into memory at the group's last address.
//
// Ports
//   clk, reset          posedge clock; asynchronous active-low reset
//   address, rden, wren FSM port A: synchronous read into q_a, write of acc
//   load, transf        opnd <= q_a ; acc <= acc + opnd (sticky carry-out)
//   clear               active-low synchronous clear of acc, opnd, carry
//   host_we/addr/wdata  host port B write
//   host_rdata          registered mem[host_addr], every cycle
//   acc_out             current accumulator
//   grp_valid/idx/sum/carry  one-cycle record of each port-A write
//   host_err            one-cycle pulse when a host write loses a collision
module somador_datapath #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        address,
  input  logic              rden,
  input  logic              wren,
  input  logic              load,
  input  logic              clear,
  input  logic              transf,
  input  logic              host_we,
  input  logic [4:0]        host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] acc_out,
  output logic              grp_valid,
  output logic [1:0]        grp_idx,
  output logic [DATA_W-1:0] grp_sum,
  output logic              grp_carry,
  output logic              host_err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q_a;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] acc;
  logic              carry;
  logic [DATA_W:0]   sum;
  logic              collision;

  assign sum       = {1'b0, acc} + {1'b0, opnd};
  assign collision = wren && host_we && (address == host_addr);
  assign acc_out   = acc;

  // Memory array is never reset. Port A wins a same-address collision; the
  // FSM port is ignored while reset is held so a run cannot corrupt memory.
  always_ff @(posedge clk) begin
    if (reset && wren)
      mem[address] <= acc;
    if (host_we && !(reset && collision))
      mem[host_addr] <= host_wdata;
  end

  // Synchronous reads see the pre-write contents on a same-address write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_a        <= '0;
      host_rdata <= '0;
    end else begin
      if (rden)
        q_a <= mem[address];
      host_rdata <= mem[host_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      opnd  <= '0;
      carry <= 1'b0;
    end else if (!clear) begin
      acc   <= '0;
      opnd  <= '0;
      carry <= 1'b0;
    end else begin
      if (load)
        opnd <= q_a;
      // Uses the pre-load opnd when load and transf coincide.
      if (transf) begin
        acc <= sum[DATA_W-1:0];
        if (sum[DATA_W])
          carry <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grp_valid <= 1'b0;
      grp_idx   <= '0;
      grp_sum   <= '0;
      grp_carry <= 1'b0;
      host_err  <= 1'b0;
    end else begin
      grp_valid <= wren;
      host_err  <= collision;
      if (wren) begin
        grp_idx   <= address[4:3];
        grp_sum   <= acc;
        grp_carry <= carry;
      end
    end
  end

endmodule

// File: tb/tb_somador_datapath.sv
`timescale 1ns/1ps
module tb_somador_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] address;
  logic       rden, wren, load, clear, transf;
  logic       host_we;
  logic [4:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata, acc_out, grp_sum;
  logic       grp_valid, grp_carry, host_err;
  logic [1:0] grp_idx;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  somador_datapath #(.DATA_W(8), .DEPTH(32)) dut (
    .clk(clk), .reset(reset), .address(address), .rden(rden), .wren(wren),
    .load(load), .clear(clear), .transf(transf), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .acc_out(acc_out), .grp_valid(grp_valid), .grp_idx(grp_idx),
    .grp_sum(grp_sum), .grp_carry(grp_carry), .host_err(host_err)
  );

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  task automatic clear_pulse();
    @(negedge clk); clear = 1'b0;
    @(negedge clk); clear = 1'b1;
  endtask

  task automatic rload(input logic [4:0] a, input logic do_transf);
    @(negedge clk); rden = 1'b1; address = a;
    @(negedge clk); rden = 1'b0; load = 1'b1;
    @(negedge clk); load = 1'b0; transf = do_transf;
    if (do_transf) begin
      @(negedge clk); transf = 1'b0;
    end
  endtask

  // -------------------------- scenarios ------------------------------
  task automatic run_group(input int g, input logic [7:0] exp_sum, input logic exp_carry);
    clear_pulse();
    for (int i = 0; i < 8; i++) rload(5'(g * 8 + i), 1'b1);
    @(negedge clk); wren = 1'b1; address = 5'(g * 8 + 7);
    @(negedge clk); wren = 1'b0;
    checks++; if (grp_valid !== 1'b1) $display("FAIL grp%0d_valid got=%b exp=1", g, grp_valid); else passed++;
    checks++; if (grp_idx !== 2'(g)) $display("FAIL grp%0d_idx got=%0d exp=%0d", g, grp_idx, g); else passed++;
    checks++; if (grp_sum !== exp_sum) $display("FAIL grp%0d_sum got=%0d exp=%0d", g, grp_sum, exp_sum); else passed++;
    checks++; if (grp_carry !== exp_carry) $display("FAIL grp%0d_carry got=%b exp=%b", g, grp_carry, exp_carry); else passed++;
    @(negedge clk);
    checks++; if (grp_valid !== 1'b0) $display("FAIL grp%0d_valid_pulse got=%b exp=0", g, grp_valid); else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0; address = '0; rden = 0; wren = 0; load = 0; clear = 1'b1;
    transf = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    #12;
    checks++; if (acc_out !== 8'd0) $display("FAIL rst_acc got=%0d exp=0", acc_out); else passed++;
    checks++; if (grp_valid !== 1'b0) $display("FAIL rst_grp_valid got=%b exp=0", grp_valid); else passed++;
    checks++; if (host_err !== 1'b0) $display("FAIL rst_host_err got=%b exp=0", host_err); else passed++;
    checks++; if (host_rdata !== 8'd0) $display("FAIL rst_host_rdata got=%0d exp=0", host_rdata); else passed++;
    checks++; if ({grp_sum, grp_carry, grp_idx} !== 11'd0) $display("FAIL rst_grp_regs got=%h exp=0", {grp_sum, grp_carry, grp_idx}); else passed++;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_basic_sum();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) host_write(5'(i), 8'(i + 1));
    run_group(0, 8'd36, 1'b0);
    host_read(5'd7, d);
    checks++; if (d !== 8'd36) $display("FAIL basic_mem7 got=%0d exp=36", d); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 8; i < 16; i++) host_write(5'(i), 8'h40);
    for (int i = 16; i < 24; i++) host_write(5'(i), 8'h01);
    run_group(1, 8'h00, 1'b1);
    run_group(2, 8'd8, 1'b0);
  endtask

  task automatic test_full_run();
    logic [7:0] d;
    for (int i = 0; i < 32; i++) host_write(5'(i), 8'(i));
    run_group(0, 8'd28, 1'b0);
    run_group(1, 8'd92, 1'b0);
    run_group(2, 8'd156, 1'b0);
    run_group(3, 8'd220, 1'b0);
    host_read(5'd30, d);
    checks++; if (d !== 8'd30) $display("FAIL full_mem30 got=%0d exp=30", d); else passed++;
    @(negedge clk); host_addr = 5'd31;
    #1;
    checks++; if (host_rdata !== 8'd30) $display("FAIL full_rd_latency got=%0d exp=30", host_rdata); else passed++;
    @(negedge clk);
    checks++; if (host_rdata !== 8'd220) $display("FAIL full_mem31 got=%0d exp=220", host_rdata); else passed++;
  endtask

  task automatic test_collision();
    logic [7:0] d;
    for (int i = 8; i < 16; i++) host_write(5'(i), 8'(i));
    clear_pulse();
    for (int i = 8; i < 16; i++) rload(5'(i), 1'b1);
    checks++; if (acc_out !== 8'd92) $display("FAIL coll_acc got=%0d exp=92", acc_out); else passed++;
    @(negedge clk);
    wren = 1'b1; address = 5'd15; host_we = 1'b1; host_addr = 5'd15; host_wdata = 8'hAA;
    @(negedge clk);
    wren = 1'b0; host_we = 1'b0;
    checks++; if (host_err !== 1'b1) $display("FAIL coll_err got=%b exp=1", host_err); else passed++;
    @(negedge clk);
    checks++; if (host_err !== 1'b0) $display("FAIL coll_err_pulse got=%b exp=0", host_err); else passed++;
    host_read(5'd15, d);
    checks++; if (d !== 8'd92) $display("FAIL coll_mem15 got=%0d exp=92", d); else passed++;
    @(negedge clk);
    wren = 1'b1; address = 5'd15; host_we = 1'b1; host_addr = 5'd3; host_wdata = 8'h33;
    @(negedge clk);
    wren = 1'b0; host_we = 1'b0;
    checks++; if (host_err !== 1'b0) $display("FAIL diff_err got=%b exp=0", host_err); else passed++;
    host_read(5'd3, d);
    checks++; if (d !== 8'h33) $display("FAIL diff_mem3 got=%0d exp=51", d); else passed++;
    host_read(5'd15, d);
    checks++; if (d !== 8'd92) $display("FAIL diff_mem15 got=%0d exp=92", d); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) host_write(5'(i), 8'(i + 1));
    clear_pulse();
    for (int i = 0; i < 4; i++) rload(5'(i), 1'b1);
    checks++; if (acc_out !== 8'd10) $display("FAIL mid_acc got=%0d exp=10", acc_out); else passed++;
    @(negedge clk); #2 reset = 1'b0;
    #1;
    checks++; if (acc_out !== 8'd0) $display("FAIL mid_rst_acc got=%0d exp=0", acc_out); else passed++;
    checks++; if (grp_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", grp_valid); else passed++;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_read(5'(i), d);
      checks++; if (d !== 8'(i + 1)) $display("FAIL mid_mem%0d got=%0d exp=%0d", i, d, i + 1); else passed++;
    end
  endtask

  task automatic test_clear_priority();
    for (int i = 8; i < 16; i++) host_write(5'(i), 8'h40);
    host_write(5'd0, 8'd1);
    host_write(5'd1, 8'd2);
    clear_pulse();
    for (int i = 8; i < 16; i++) rload(5'(i), 1'b1);
    rload(5'd0, 1'b1);
    checks++; if (acc_out !== 8'd1) $display("FAIL clrp_pre_acc got=%0d exp=1", acc_out); else passed++;
    @(negedge clk); clear = 1'b0; transf = 1'b1; load = 1'b1;
    @(negedge clk); clear = 1'b1; transf = 1'b0; load = 1'b0;
    checks++; if (acc_out !== 8'd0) $display("FAIL clrp_acc got=%0d exp=0", acc_out); else passed++;
    @(negedge clk); wren = 1'b1; address = 5'd7;
    @(negedge clk); wren = 1'b0;
    checks++; if (grp_sum !== 8'd0) $display("FAIL clrp_sum got=%0d exp=0", grp_sum); else passed++;
    checks++; if (grp_carry !== 1'b0) $display("FAIL clrp_carry got=%b exp=0", grp_carry); else passed++;
  endtask

  task automatic test_load_transf_same_cycle();
    clear_pulse();
    rload(5'd0, 1'b0);
    @(negedge clk); rden = 1'b1; address = 5'd1;
    @(negedge clk); rden = 1'b0; load = 1'b1; transf = 1'b1;
    @(negedge clk); load = 1'b0; transf = 1'b0;
    checks++; if (acc_out !== 8'd1) $display("FAIL lt_old_opnd got=%0d exp=1", acc_out); else passed++;
    @(negedge clk); transf = 1'b1;
    @(negedge clk); transf = 1'b0;
    checks++; if (acc_out !== 8'd3) $display("FAIL lt_new_opnd got=%0d exp=3", acc_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_overflow();
    test_full_run();
    test_collision();
    test_reset_mid();
    test_clear_priority();
    test_load_transf_same_cycle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/somador_datapath.md
# somador_datapath

Datapath consumed by the summation control FSM. It holds the 32-word operand/result memory, the operand load register and the accumulator. It executes the FSM's rden/load/transf/clear/wren strobes and writes each 8-word group sum back into the memory at the group's last address. A host port fills the memory before a run and reads results after `ready`. Group results are also streamed out with a one-cycle valid pulse.

## Interface
- DATA_W, 8, memory word, operand and accumulator width
- DEPTH, 32, memory words; fixed at 32 because the FSM's address is 5 bits
- clk  in  1  datapath clock; all state updates on posedge (the FSM updates on negedge)
- reset  in  1  reset, asynchronous, active-low
- address  in  5  FSM memory address, port A
- rden  in  1  FSM read enable, port A
- wren  in  1  FSM write enable, port A; writes the accumulator to mem[address]
- load  in  1  capture memory read data into the operand register
- clear  in  1  active-low synchronous clear of accumulator, operand register and carry
- transf  in  1  acc <= acc + operand
- host_we  in  1  host write strobe, port B
- host_addr  in  5  host address, port B
- host_wdata  in  DATA_W  host write data
- host_rdata  out  DATA_W  registered mem[host_addr], every cycle
- acc_out  out  DATA_W  current accumulator
- grp_valid  out  1  one-cycle pulse, registered result of a wren
- grp_idx  out  2  address[4:3] of the wren that produced the result
- grp_sum  out  DATA_W  value written by that wren
- grp_carry  out  1  sticky carry of that group at write time
- host_err  out  1  one-cycle pulse; host write dropped

## Operation
- Memory: dual-port, DEPTH x DATA_W, synchronous read. Contents are not reset.
- Port A read: if rden=1 at posedge N, then q_a = mem[address] after posedge N. q_a holds its value while rden=0.
- load=1 at a posedge: opnd <= q_a. The FSM holds rden for one state before load, so q_a is valid.
- transf=1: acc <= acc + opnd, modulo 2^DATA_W. If the carry-out is 1, carry <= 1 (sticky).
- clear=0: acc, opnd and carry <= 0. This has priority over load and transf in the same cycle.
- wren=1: mem[address] <= acc, and on the same edge grp_sum <= acc, grp_carry <= carry, grp_idx <= address[4:3], grp_valid <= 1. Otherwise grp_valid <= 0.
- Port B: host_rdata <= mem[host_addr] every posedge. host_we=1 writes mem[host_addr] <= host_wdata.
- Collision, both ports writing the same address in the same cycle: port A wins, the host write is dropped, and host_err pulses for 1 cycle. Writes to different addresses both commit.
- Read during write, either port, same address: returns the old data.
- The datapath does no sequencing of its own; strobe ordering is the FSM's responsibility. Simultaneous load+transf uses the old opnd for the add.

## Timing
- Reset (async, reset=0): acc, opnd, q_a, carry, host_rdata, grp_sum, grp_carry, grp_idx <= 0; grp_valid, host_err <= 0. Memory contents are kept.
- Reset mid-run clears the accumulator immediately. A partially summed group is lost; the FSM restarts from address 0.
- Latencies:
  - rden to q_a: 1 posedge.
  - load to opnd: 1 posedge.
  - transf to acc: 1 posedge.
  - wren to memory and to grp_valid: 1 posedge.
  - host read: 1 posedge.
- Per group:
  - The FSM issues clear=0 once at group start.
  - It then issues 8 rden/load/transf sequences.
  - It then issues wren at address 7, 15, 23 or 31. The write overwrites that group's 8th operand with the sum.
- Wrap: an acc overflow wraps silently and is flagged only via grp_carry. Carry stays set until the next clear=0.
- grp_valid rises exactly 4 times per full run, with grp_idx 0,1,2,3 in order.

## Test plan
- Basic sum: mem[0..7]=1..8. Run the FSM sequence → grp_valid with grp_idx=0, grp_sum=36, grp_carry=0; mem[7]=36.
- Overflow: mem[8..15]=0x40 each (sum 0x200) → grp_sum=0x00, grp_carry=1, grp_idx=1. The next group, after clear, reports grp_carry=0.
- Full run: all 32 words = index value → grp_sum 28, 92, 156 (0x9C), 220 (0xDC) for groups 0-3. Host reads addr 31 → 220, with 1-cycle latency.
- Collision: host_we to addr 15 in the same cycle as FSM wren to 15 → mem[15]=acc, host_err=1 for one cycle. A host write to addr 3 in the same cycle commits.
- Reset mid-group: assert reset=0 after 4 transfs of group 0 → acc_out=0 and grp_valid=0 immediately. Memory contents are unchanged (host readback).
- Clear priority: clear=0 together with transf=1 → acc=0, carry=0 on that edge.
